// File: rtl/student_ram4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// student_ram4 : 4-entry register file with per-entry valid bits and bulk clear
// Revision     : 1.0
// ----------------------------------------------------------------------------
module student_ram4 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [1:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [2:0]       count
);

  logic [WIDTH-1:0] mem_q [4];
  logic [WIDTH-1:0] mem_d [4];
  logic [3:0]       vbit_q;
  logic [3:0]       vbit_d;
  logic             ld_a, ld_b, ld_c, ld_d;
  logic [3:0]       ld;

  // dmux4way: the single load strobe is steered to one word by address
  always_comb begin
    ld_a = load & (address == 2'b00);
    ld_b = load & (address == 2'b01);
    ld_c = load & (address == 2'b10);
    ld_d = load & (address == 2'b11);
    ld   = {ld_d, ld_c, ld_b, ld_a};
  end

  always_comb begin
    vbit_d = vbit_q;
    for (int i = 0; i < 4; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (clear) begin
      vbit_d = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        mem_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ld[i]) begin
          mem_d[i]  = in;
          vbit_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vbit_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vbit_q <= vbit_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    out   = mem_q[address];
    valid = vbit_q[address];
    count = {2'b00, vbit_q[0]} + {2'b00, vbit_q[1]}
          + {2'b00, vbit_q[2]} + {2'b00, vbit_q[3]};
  end

endmodule
`default_nettype wire

// File: tb/tb_student_ram4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_student_ram4 : vector table plus scoreboard bench for student_ram4
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_student_ram4;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             load;
  logic [1:0]       address;
  logic             clear;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic [2:0]       count;

  student_ram4 #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .valid   (valid),
    .count   (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             r;
    logic             c;
    logic             l;
    logic [1:0]       a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] eo;
    logic             ev;
    logic [2:0]       ec;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] eo;
    logic             ev;
    logic [2:0]       ec;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic c, input logic l, input logic [1:0] a,
                     input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] eo,
                     input logic ev, input logic [2:0] ec);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.a = a; v.d = d; v.eo = eo; v.ev = ev; v.ec = ec;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, queue the expectation,
  // then compare the combinational read before the next rising edge.
  task automatic step(input int idx, input logic r, input logic c, input logic l,
                      input logic [1:0] a, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] eo, input logic ev, input logic [2:0] ec);
    exp_t e;
    @(negedge clk);
    reset = r; clear = c; load = l; address = a; in = d;
    e.eo = eo; e.ev = ev; e.ec = ec;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard step %0d: got empty queue, expected one entry", idx);
    end else begin
      e = sb.pop_front();
      check("out",   idx, 32'(out),   32'(e.eo));
      check("valid", idx, 32'(valid), 32'(e.ev));
      check("count", idx, 32'(count), 32'(e.ec));
    end
  endtask

  logic [WIDTH-1:0] model [4];
  logic [WIDTH-1:0] rnd;

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; address = 2'd0; in = '0;

    //   r     c     l     a     d         out       v     cnt
    // reset sweep
    add(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b0, 2'd3, 16'h0000, 16'h0000, 1'b0, 3'd0);
    // routed writes: old value visible during the write cycle
    add(1'b0, 1'b0, 1'b1, 2'd0, 16'h1111, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b1, 2'd1, 16'h2222, 16'h0000, 1'b0, 3'd1);
    add(1'b0, 1'b0, 1'b1, 2'd2, 16'h3333, 16'h0000, 1'b0, 3'd2);
    add(1'b0, 1'b0, 1'b1, 2'd3, 16'h4444, 16'h0000, 1'b0, 3'd3);
    add(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h1111, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd1, 16'h0000, 16'h2222, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd2, 16'h0000, 16'h3333, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd3, 16'h0000, 16'h4444, 1'b1, 3'd4);
    // load=0 with all-ones data must not write
    add(1'b0, 1'b0, 1'b0, 2'd0, 16'hFFFF, 16'h1111, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd1, 16'hFFFF, 16'h2222, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd2, 16'hFFFF, 16'h3333, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd3, 16'hFFFF, 16'h4444, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h1111, 1'b1, 3'd4);
    // overwrite entry 2
    add(1'b0, 1'b0, 1'b1, 2'd2, 16'hBEEF, 16'h3333, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd2, 16'h0000, 16'hBEEF, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd1, 16'h0000, 16'h2222, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd3, 16'h0000, 16'h4444, 1'b1, 3'd4);
    // clear wins over a simultaneous write
    add(1'b0, 1'b1, 1'b1, 2'd1, 16'hAAAA, 16'h2222, 1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b1, 2'd3, 16'h0005, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b0, 2'd3, 16'h0000, 16'h0005, 1'b1, 3'd1);
    add(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd1);
    // reset wins over a simultaneous write
    add(1'b0, 1'b0, 1'b1, 2'd0, 16'h1234, 16'h0000, 1'b0, 3'd1);
    add(1'b1, 1'b0, 1'b1, 2'd0, 16'h5678, 16'h1234, 1'b1, 3'd2);
    add(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0);
    add(1'b0, 1'b0, 1'b0, 2'd3, 16'h0000, 16'h0000, 1'b0, 3'd0);
    // reset and clear together
    add(1'b0, 1'b0, 1'b1, 2'd1, 16'hFFFF, 16'h0000, 1'b0, 3'd0);
    add(1'b1, 1'b1, 1'b0, 2'd1, 16'h0000, 16'hFFFF, 1'b1, 3'd1);
    add(1'b0, 1'b0, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 3'd0);

    // start from a known state before the table
    repeat (2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step(i, tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].a, tbl[i].d,
           tbl[i].eo, tbl[i].ev, tbl[i].ec);
    end

    // Fill all four entries with random words (address hops every cycle),
    // then keep writing: count must saturate at 4 and data must track a model.
    for (int i = 0; i < 4; i++) model[i] = '0;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] a;
      logic [2:0] cnt;
      a   = 2'(i % 4);
      rnd = 16'($urandom);
      cnt = (i < 4) ? 3'(i) : 3'd4;
      step(1000 + i, 1'b0, 1'b0, 1'b1, a, rnd, model[a], (i >= 4), cnt);
      model[a] = rnd;
    end
    for (int i = 0; i < 4; i++) begin
      step(2000 + i, 1'b0, 1'b0, 1'b0, 2'(i), 16'h0000, model[i], 1'b1, 3'd4);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire
